// File: rtl/txtsu_ts_queue.sv
// Merges TX timestamp reports from several endpoints into one FWFT FIFO.
// Round-robin arbitration with per-port re-arming, one-cycle ack, and sticky drop accounting.
module txtsu_ts_queue #(
  parameter int g_num_ports = 2,
  parameter int g_depth     = 8
) (
  input  logic                      clk_sys_i,
  input  logic                      rst_n_i,
  input  logic [g_num_ports-1:0]    txtsu_valid_i,
  output logic [g_num_ports-1:0]    txtsu_ack_o,
  input  logic [5*g_num_ports-1:0]  txtsu_port_id_i,
  input  logic [16*g_num_ports-1:0] txtsu_frame_id_i,
  input  logic [32*g_num_ports-1:0] txtsu_ts_i,
  output logic                      q_valid_o,
  output logic [4:0]                q_port_id_o,
  output logic [15:0]               q_frame_id_o,
  output logic [31:0]               q_ts_o,
  input  logic                      q_pop_i,
  output logic [6:0]                q_count_o,
  output logic                      q_overflow_o,
  output logic [7:0]                q_drop_cnt_o,
  input  logic                      q_clr_i,
  output logic                      irq_o
);
  localparam int PW = (g_num_ports > 1) ? $clog2(g_num_ports) : 1;
  localparam int AW = $clog2(g_depth);

  typedef struct packed {
    logic [4:0]  port_id;
    logic [15:0] frame_id;
    logic [31:0] ts;
  } entry_t;

  logic [g_num_ports-1:0] armed_q, armed_d, ack_q, ack_d, elig;
  logic [PW-1:0]          prio_q, grant_idx;
  logic                   grant;
  entry_t                 mem_q [g_depth];
  entry_t                 head_q, head_d, wr_entry;
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [6:0]             count_q, count_d;
  logic                   valid_q, ovf_q, pop_eff, push_eff, drop;
  logic [7:0]             drop_q;

  // Walk from the lowest priority upward so the highest-priority eligible port is assigned last.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    elig      = txtsu_valid_i & armed_q;
    grant     = 1'b0;
    grant_idx = '0;
    for (int i = g_num_ports - 1; i >= 0; i--) begin
      if (elig[PW'((int'(prio_q) + i) % g_num_ports)]) begin
        grant     = 1'b1;
        grant_idx = PW'((int'(prio_q) + i) % g_num_ports);
      end
    end
    wr_entry = '0;
    ack_d    = '0;
    for (int p = 0; p < g_num_ports; p++) begin
      if (grant_idx == PW'(p)) begin
        wr_entry = '{txtsu_port_id_i[5*p +: 5], txtsu_frame_id_i[16*p +: 16], txtsu_ts_i[32*p +: 32]};
      end
      armed_d[p] = (grant && grant_idx == PW'(p)) ? 1'b0 : (armed_q[p] | ~txtsu_valid_i[p]);
    end
    if (grant) ack_d[grant_idx] = 1'b1;
  end

  // Fullness is judged after the same-cycle pop, so a full FIFO can pop and push together.
  always_comb begin
    pop_eff  = q_pop_i && (count_q != 7'd0);
    drop     = grant && (count_q == 7'(g_depth)) && !pop_eff;
    push_eff = grant && !drop;
    rd_ptr_d = rd_ptr_q + AW'(pop_eff);
    count_d  = count_q + 7'(push_eff) - 7'(pop_eff);
    head_d   = (push_eff && wr_ptr_q == rd_ptr_d) ? wr_entry : mem_q[rd_ptr_d];
  end

  // NOTE: storage has no reset; only pointers and count define which slots hold data.
  always_ff @(posedge clk_sys_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= wr_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      armed_q  <= '1;
      ack_q    <= '0;
      prio_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      armed_q  <= armed_d;
      ack_q    <= ack_d;
      if (grant) prio_q <= (grant_idx == PW'(g_num_ports - 1)) ? '0 : grant_idx + PW'(1);
      if (push_eff) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != 7'd0);
      head_q   <= head_d;
      if (drop) begin
        ovf_q  <= 1'b1;
        drop_q <= q_clr_i ? 8'd1 : ((drop_q == 8'hFF) ? 8'hFF : drop_q + 8'd1);
      end else if (q_clr_i) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

  assign txtsu_ack_o  = ack_q;
  assign q_valid_o    = valid_q;
  assign irq_o        = valid_q;
  assign q_port_id_o  = head_q.port_id;
  assign q_frame_id_o = head_q.frame_id;
  assign q_ts_o       = head_q.ts;
  assign q_count_o    = count_q;
  assign q_overflow_o = ovf_q;
  assign q_drop_cnt_o = drop_q;
endmodule

// File: tb/tb_txtsu_ts_queue.sv
// Self-checking bench for txtsu_ts_queue: table vectors, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_txtsu_ts_queue;
  localparam int N = 2;
  localparam int D = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    valid;
  logic [N-1:0]    ack;
  logic [5*N-1:0]  port_id;
  logic [16*N-1:0] frame_id;
  logic [32*N-1:0] ts;
  logic            q_valid, q_pop, q_overflow, q_clr, irq;
  logic [4:0]      q_port_id;
  logic [15:0]     q_frame_id;
  logic [31:0]     q_ts;
  logic [6:0]      q_count;
  logic [7:0]      q_drop_cnt;

  int n_checks = 0;
  int n_err    = 0;

  txtsu_ts_queue #(.g_num_ports(N), .g_depth(D)) dut (
    .clk_sys_i(clk), .rst_n_i(rst_n),
    .txtsu_valid_i(valid), .txtsu_ack_o(ack),
    .txtsu_port_id_i(port_id), .txtsu_frame_id_i(frame_id), .txtsu_ts_i(ts),
    .q_valid_o(q_valid), .q_port_id_o(q_port_id), .q_frame_id_o(q_frame_id), .q_ts_o(q_ts),
    .q_pop_i(q_pop), .q_count_o(q_count), .q_overflow_o(q_overflow),
    .q_drop_cnt_o(q_drop_cnt), .q_clr_i(q_clr), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of reports plus arbitration bookkeeping.
  logic [52:0] m_q[$];
  bit          m_armed[N];
  int          m_prio;
  logic [N-1:0] m_ack;
  bit          m_ovf;
  int          m_drop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  g;
    bit  dropped;
    if (!rst_n) begin
      m_q.delete();
      for (int p = 0; p < N; p++) m_armed[p] = 1'b1;
      m_prio = 0;
      m_ack  = '0;
      m_ovf  = 1'b0;
      m_drop = 0;
      return;
    end
    g = -1;
    for (int i = 0; i < N; i++) begin
      int p;
      p = (m_prio + i) % N;
      if (valid[p] && m_armed[p]) begin
        g = p;
        break;
      end
    end
    if (q_pop && m_q.size() > 0) void'(m_q.pop_front());
    dropped = 1'b0;
    m_ack   = '0;
    for (int p = 0; p < N; p++) if (p != g && !valid[p]) m_armed[p] = 1'b1;
    if (g >= 0) begin
      m_ack[g]   = 1'b1;
      m_armed[g] = 1'b0;
      m_prio     = (g + 1) % N;
      if (m_q.size() < D) m_q.push_back({port_id[5*g +: 5], frame_id[16*g +: 16], ts[32*g +: 32]});
      else dropped = 1'b1;
    end
    if (dropped) begin
      m_ovf  = 1'b1;
      m_drop = q_clr ? 1 : ((m_drop >= 255) ? 255 : m_drop + 1);
    end else if (q_clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
  endtask

  // One clock: advance the model with the inputs the DUT is about to sample, then compare.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("ack", 64'(ack), 64'(m_ack));
    check("q_valid", 64'(q_valid), 64'(m_q.size() > 0));
    check("irq", 64'(irq), 64'(m_q.size() > 0));
    check("count", 64'(q_count), 64'(m_q.size()));
    check("overflow", 64'(q_overflow), 64'(m_ovf));
    check("drop_cnt", 64'(q_drop_cnt), 64'(m_drop));
    if (m_q.size() > 0) begin
      check("head_port", 64'(q_port_id), 64'(m_q[0][52:48]));
      check("head_frame", 64'(q_frame_id), 64'(m_q[0][47:32]));
      check("head_ts", 64'(q_ts), 64'(m_q[0][31:0]));
    end
  endtask

  task automatic pulse(input int p, input logic [15:0] fid);
    frame_id[16*p +: 16] = fid;
    valid[p] = 1'b1;
    tick();
    valid[p] = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_valid"}, 64'(q_valid), 64'd0);
    check({tag, "_irq"}, 64'(irq), 64'd0);
    check({tag, "_count"}, 64'(q_count), 64'd0);
    check({tag, "_ovf"}, 64'(q_overflow), 64'd0);
    check({tag, "_drop"}, 64'(q_drop_cnt), 64'd0);
    check({tag, "_port"}, 64'(q_port_id), 64'd0);
    check({tag, "_frame"}, 64'(q_frame_id), 64'd0);
    check({tag, "_ts"}, 64'(q_ts), 64'd0);
  endtask

  typedef struct {
    bit          rst;
    logic [1:0]  valid;
    logic [15:0] f0;
    logic [15:0] f1;
    bit          pop;
    logic [1:0]  ack;
    int          count;
    logic [15:0] head;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // Single-port handshake, then a reset and a simultaneous two-port request.
    vecs[0]  = '{0, 2'b01, 16'h0042, 16'h0000, 0, 2'b01, 1, 16'h0042};
    vecs[1]  = '{0, 2'b01, 16'h0042, 16'h0000, 0, 2'b00, 1, 16'h0042};
    vecs[2]  = '{0, 2'b01, 16'h0042, 16'h0000, 0, 2'b00, 1, 16'h0042};
    vecs[3]  = '{0, 2'b01, 16'h0042, 16'h0000, 0, 2'b00, 1, 16'h0042};
    vecs[4]  = '{0, 2'b00, 16'h0042, 16'h0000, 1, 2'b00, 0, 16'h0000};
    vecs[5]  = '{1, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 0, 16'h0000};
    vecs[6]  = '{0, 2'b11, 16'h0010, 16'h0020, 0, 2'b01, 1, 16'h0010};
    vecs[7]  = '{0, 2'b11, 16'h0010, 16'h0020, 0, 2'b10, 2, 16'h0010};
    vecs[8]  = '{0, 2'b00, 16'h0010, 16'h0020, 0, 2'b00, 2, 16'h0010};
    vecs[9]  = '{0, 2'b00, 16'h0010, 16'h0020, 1, 2'b00, 1, 16'h0020};
    vecs[10] = '{0, 2'b00, 16'h0010, 16'h0020, 1, 2'b00, 0, 16'h0000};

    rst_n = 1'b0; valid = '0; q_pop = 1'b0; q_clr = 1'b0;
    port_id = '0; frame_id = '0; ts = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    port_id[4:0] = 5'd1;  ts[31:0]  = 32'h1234_5678;
    port_id[9:5] = 5'd2;  ts[63:32] = 32'hCAFE_BABE;
    for (int i = 0; i < 11; i++) begin
      rst_n = !vecs[i].rst;
      valid = vecs[i].valid;
      frame_id[15:0]  = vecs[i].f0;
      frame_id[31:16] = vecs[i].f1;
      q_pop = vecs[i].pop;
      tick();
      check($sformatf("vec%0d_ack", i), 64'(ack), 64'(vecs[i].ack));
      check($sformatf("vec%0d_count", i), 64'(q_count), 64'(vecs[i].count));
      if (vecs[i].count > 0) check($sformatf("vec%0d_head", i), 64'(q_frame_id), 64'(vecs[i].head));
      if (i == 0) begin
        check("vec0_port", 64'(q_port_id), 64'd1);
        check("vec0_ts", 64'(q_ts), 64'h1234_5678);
      end
    end
    rst_n = 1'b1; valid = '0; q_pop = 1'b0;

    // Fill to depth, then one more report is acked but dropped.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 0; k < D; k++) pulse(0, 16'(k));
    frame_id[15:0] = 16'h0008;
    valid[0] = 1'b1;
    tick();
    check("full_ack9", 64'(ack), 64'h1);
    valid[0] = 1'b0;
    tick();
    check("full_count", 64'(q_count), 64'd8);
    check("full_ovf", 64'(q_overflow), 64'd1);
    check("full_drop", 64'(q_drop_cnt), 64'd1);
    check("full_head", 64'(q_frame_id), 64'h0);
    q_clr = 1'b1; tick(); q_clr = 1'b0;
    check("clr_ovf", 64'(q_overflow), 64'd0);
    check("clr_drop", 64'(q_drop_cnt), 64'd0);

    // Full FIFO: pop and grant in the same cycle is accepted without a drop.
    frame_id[31:16] = 16'h0099;
    valid[1] = 1'b1; q_pop = 1'b1;
    tick();
    valid[1] = 1'b0; q_pop = 1'b0;
    check("poppush_ack", 64'(ack), 64'h2);
    check("poppush_count", 64'(q_count), 64'd8);
    check("poppush_ovf", 64'(q_overflow), 64'd0);
    check("poppush_head", 64'(q_frame_id), 64'h1);
    q_pop = 1'b1; repeat (7) tick(); q_pop = 1'b0;
    check("tail_entry", 64'(q_frame_id), 64'h0099);
    check("tail_count", 64'(q_count), 64'd1);

    // Saturating drop counter, clear, and clear coincident with a drop.
    for (int k = 0; k < D - 1; k++) pulse(0, 16'(16'h100 + k));
    for (int k = 0; k < 300; k++) pulse(0, 16'hDEAD);
    check("sat_drop", 64'(q_drop_cnt), 64'd255);
    check("sat_ovf", 64'(q_overflow), 64'd1);
    q_clr = 1'b1; tick();
    check("sat_clr_drop", 64'(q_drop_cnt), 64'd0);
    check("sat_clr_ovf", 64'(q_overflow), 64'd0);
    valid[0] = 1'b1; tick();
    check("clr_drop_win_ovf", 64'(q_overflow), 64'd1);
    check("clr_drop_win_cnt", 64'(q_drop_cnt), 64'd1);
    valid[0] = 1'b0; q_clr = 1'b0; tick();

    // Reset mid-operation with port 1 requesting; the held valid is accepted once afterwards.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) pulse(0, 16'(16'h200 + k));
    check("pre_rst_count", 64'(q_count), 64'd3);
    frame_id[31:16] = 16'h0066;
    valid[1] = 1'b1; rst_n = 1'b0;
    tick();
    check_all_zero("midrst");
    rst_n = 1'b1;
    tick();
    check("post_rst_ack", 64'(ack), 64'h2);
    check("post_rst_head", 64'(q_frame_id), 64'h0066);
    tick(); tick();
    check("post_rst_once_ack", 64'(ack), 64'h0);
    check("post_rst_once_count", 64'(q_count), 64'd1);
    valid = '0; tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      valid    = N'($urandom);
      port_id  = (5*N)'({$urandom, $urandom});
      frame_id = (16*N)'({$urandom, $urandom});
      ts       = {$urandom, $urandom};
      q_pop    = ($urandom_range(0, 2) == 0);
      q_clr    = ($urandom_range(0, 40) == 0);
      rst_n    = ($urandom_range(0, 700) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
